inpkt_parser: RTL
=================

// Module: inpkt_parser
// PURPOSE
//  Input-packet parser between the high-speed input FIFO (8-bit FWFT read side, PKT_COMM_CLK) and the application core.
//  - Consumes the byte stream and decodes the 10-byte header, then checks the 4-byte header checksum.
//  - Forwards the payload bytes downstream.
//  - Raises sticky error bits that are OR'ed into pkt_comm_status. Any error halts all reads until reset.
// PARAMETERS
//  VERSION      2        required header version byte
//  PKT_MAX_LEN  65536    max payload length in bytes (1..2^24-1)
//  TYPE_MASK    8'h0E    bit t set = packet type t is accepted
// PORTS
//  CLK           in   1   PKT_COMM_CLK domain
//  rst_n         in   1   reset, asynchronous, active-low
//  din           in   8   input FIFO data; valid while !empty (FWFT)
//  empty         in   1   input FIFO empty
//  rd_en         out  1   pop input FIFO
//  dout          out  8   payload byte
//  wr_en         out  1   payload byte valid, one cycle per byte
//  full          in   1   downstream cannot accept a byte
//  pkt_type      out  8   type of the current packet; held until the next header completes
//  pkt_id        out  16  packet id (little-endian)
//  pkt_len       out  24  payload length (little-endian)
//  pkt_start     out  1   1-cycle pulse when the header checksum passes
//  pkt_end       out  1   1-cycle pulse when the packet is fully accepted
//  err           out  8   sticky: [0]version [1]type [2]reserved!=0 [3]len [4]hdr cksum [5]payload cksum; [7:6]=0
// BEHAVIOUR
//  - Reset values: all outputs 0; state HDR; counters 0; checksum accumulator 0.
//  - Header bytes, in order:
//      0 version; 1 type; 2-3 reserved; 4-6 len (LSB first); 7 reserved; 8-9 id.
//  - Read rule: rd_en = !empty & (state!=ERROR) & !(state==PAYLOAD & full). Combinational.
//    A byte is consumed in the cycle rd_en=1.
//  - Payload timing: dout/wr_en are registered, 1 cycle after the byte is consumed. Payload is never dropped or duplicated.
//  - full is sampled in the same cycle as rd_en. One extra in-flight byte after full rises is allowed
//    (downstream uses prog_full at depth-1).
//  - Checksum: 32-bit sum of the bytes packed into little-endian words, modulo 2^32, then bitwise NOT.
//    A final partial word is zero-padded. The 4-byte checksum follows, LSB first.
//  - FSM states:
//    - HDR: consume 10 bytes with a byte counter. Fields are latched into shadow registers.
//      On byte 9: checks are done on the shadow values; next state is HCKSUM.
//    - HCKSUM: consume 4 bytes; compare with ~acc. Pass -> latch outputs, pulse pkt_start, clear acc,
//      go to PAYLOAD. Fail -> err[4].
//    - PAYLOAD: forward pkt_len bytes with a 24-bit down-counter; accumulate the checksum. At count 0 -> PCKSUM.
//    - PCKSUM: consume 4 bytes. Match -> pulse pkt_end, go to HDR. Mismatch -> err[5].
//    - ERROR: terminal state; rd_en=0, wr_en=0; err is held. Only rst_n exits.
//  - Header checks run at the end of the header. Each failing check sets its bit; multiple bits may set together. Any set bit -> ERROR.
//    - err[0]: version != VERSION.
//    - err[1]: type not in TYPE_MASK.
//    - err[2]: any reserved byte != 0.
//    - err[3]: len==0 or len>PKT_MAX_LEN.
//  - empty mid-packet: the FSM stalls and holds all state. There is no timeout.
//  - Back-to-back packets: the first header byte of the next packet may be consumed in the cycle after the last PCKSUM byte.
//    pkt_end and the next pkt_start never coincide.
//  - Reset mid-packet: the FSM returns to HDR asynchronously. A partial packet is discarded; the host re-syncs by resetting.
// CONFIGURATION
//  INPKT_PAYLOAD_CKSUM_EN
//  - Defined: PCKSUM state exists; err[5] is live.
//  - Undefined: no payload checksum; the packet ends after the last payload byte. pkt_end pulses on that byte's wr_en cycle.
//    err[5] is tied to 0. The payload accumulator is removed.
// STRUCTURE
//  - Shared package/include (inpkt_defs.vh):
//    - header byte offsets; HDR_LEN=10; CKSUM_LEN=4;
//    - state encodings;
//    - error bit indices ERR_VERSION..ERR_PCKSUM.
//  - One sub-module: inpkt_cksum. Byte-in, 32-bit LE word accumulator with clear, add_en and match output.
//    Instantiated once and reused for the header and the payload.
// TESTING
//  1. Header v2, type 1, len 3, id 16'h1234, valid cksum; payload AA BB CC; valid payload cksum
//     -> pkt_start once with pkt_type=1, pkt_id=1234, pkt_len=3; dout AA,BB,CC; pkt_end; err=0.
//  2. Same packet with byte 0 = 3 -> err=8'h01 after byte 9; rd_en stays 0 while the FIFO is non-empty.
//  3. len=0 and reserved byte 2 = 8'h55 -> err=8'h0C together; no pkt_start.
//  4. Header checksum LSB flipped -> err[4]=1; no payload wr_en.
//  5. Payload of 100 bytes with random empty gaps and full held high for 20 cycles mid-payload
//     -> exactly 100 wr_en, bytes in order, at most 1 wr_en after full rises. Repeat without the macro: pkt_end on the last byte.
//  6. Two back-to-back packets, then rst_n low for 1 cycle mid-payload of a third
//     -> 2 pkt_end; after reset all outputs are 0 and a fresh packet parses correctly.

Source files
------------

// File: rtl/inpkt_parser_pkg.sv
// Shared definitions for the input packet parser: header layout,
// FSM encodings and sticky error bit positions.
package inpkt_parser_pkg;

    localparam int HDR_LEN   = 10;
    localparam int CKSUM_LEN = 4;

    localparam logic [3:0] HDR_LAST = 4'(HDR_LEN - 1);
    localparam logic [3:0] CK_LAST  = 4'(CKSUM_LEN - 1);

    localparam logic [3:0] OFF_VER  = 4'd0;
    localparam logic [3:0] OFF_TYPE = 4'd1;
    localparam logic [3:0] OFF_RSV0 = 4'd2;
    localparam logic [3:0] OFF_RSV1 = 4'd3;
    localparam logic [3:0] OFF_LEN0 = 4'd4;
    localparam logic [3:0] OFF_LEN1 = 4'd5;
    localparam logic [3:0] OFF_LEN2 = 4'd6;
    localparam logic [3:0] OFF_RSV2 = 4'd7;
    localparam logic [3:0] OFF_ID0  = 4'd8;
    localparam logic [3:0] OFF_ID1  = 4'd9;

    localparam int ERR_VERSION = 0;
    localparam int ERR_TYPE    = 1;
    localparam int ERR_RSV     = 2;
    localparam int ERR_LEN     = 3;
    localparam int ERR_HCKSUM  = 4;
    localparam int ERR_PCKSUM  = 5;

    typedef enum logic [2:0] {
        S_HDR,
        S_HCKSUM,
        S_PAYLOAD,
        S_PCKSUM,
        S_ERROR
    } state_t;

    function automatic logic type_ok(input logic [7:0] t,
                                     input logic [7:0] mask);
        return (t[7:3] == 5'd0) && mask[t[2:0]];
    endfunction

endpackage

// File: rtl/inpkt_parser_if.sv
// Byte-stream bundle of the packet parser: FIFO read side,
// payload write side and decoded header/status outputs.
interface inpkt_parser_if;
    logic [7:0]  din;
    logic        empty;
    logic        rd_en;
    logic [7:0]  dout;
    logic        wr_en;
    logic        full;
    logic [7:0]  pkt_type;
    logic [15:0] pkt_id;
    logic [23:0] pkt_len;
    logic        pkt_start;
    logic        pkt_end;
    logic [7:0]  err;

    modport slave (
        input  din, empty, full,
        output rd_en, dout, wr_en, pkt_type, pkt_id, pkt_len,
        output pkt_start, pkt_end, err
    );

    modport master (
        output din, empty, full,
        input  rd_en, dout, wr_en, pkt_type, pkt_id, pkt_len,
        input  pkt_start, pkt_end, err
    );
endinterface

// File: rtl/inpkt_cksum.sv
// Byte-fed 32-bit little-endian word checksum; match compares an
// incoming checksum byte against the matching lane of ~acc.
module inpkt_cksum (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       add_en,
    input  logic [7:0] din,
    input  logic [1:0] idx,
    output logic       match
);

    logic [31:0] acc;
    logic [31:0] inv;
    logic [1:0]  pos;

    // Adding each byte in its lane equals summing zero-padded LE words.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            pos <= '0;
        end else if (clear) begin
            acc <= '0;
            pos <= '0;
        end else if (add_en) begin
            acc <= acc + ({24'd0, din} << {pos, 3'b000});
            pos <= pos + 2'd1;
        end
    end

    assign inv   = ~acc;
    assign match = (din == inv[{idx, 3'b000} +: 8]);

endmodule

// File: rtl/inpkt_parser.sv
// Input packet parser: header decode/check, payload forwarding.
// Define INPKT_PAYLOAD_CKSUM_EN to require a trailing payload checksum.
module inpkt_parser
    import inpkt_parser_pkg::*;
#(
    parameter logic [7:0] VERSION     = 8'd2,
    parameter int         PKT_MAX_LEN = 65536,
    parameter logic [7:0] TYPE_MASK   = 8'h0E
) (
    input logic           CLK,
    input logic           rst_n,
    inpkt_parser_if.slave bus
);

    localparam logic [23:0] MAX_LEN = 24'(PKT_MAX_LEN);

    state_t      state, nxt;
    logic        rd, hdr_last, ck_last, ck_ok;
    logic        add_en, clear, match;
    logic [7:0]  err_set;
    logic [3:0]  cnt;
    logic        cbad;
    logic [23:0] rem;
    logic [7:0]  sh_ver, sh_type;
    logic [23:0] sh_len;
    logic [15:0] sh_id;
    logic        sh_rsv;
    logic [7:0]  dout_q, type_q, err_q;
    logic [15:0] id_q;
    logic [23:0] len_q;
    logic        wr_q, start_q, end_q;

    inpkt_cksum u_cksum (
        .CLK    (CLK),
        .rst_n  (rst_n),
        .clear  (clear),
        .add_en (add_en),
        .din    (bus.din),
        .idx    (cnt[1:0]),
        .match  (match)
    );

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) state <= S_HDR;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        err_set  = '0;
        add_en   = 1'b0;
        clear    = 1'b0;
        rd       = !bus.empty && (state != S_ERROR) &&
                   !(state == S_PAYLOAD && bus.full);
        hdr_last = (cnt == HDR_LAST);
        ck_last  = (cnt == CK_LAST);
        ck_ok    = !cbad && match;
        unique case (state)
            S_HDR: if (rd) begin
                add_en = 1'b1;
                if (hdr_last) begin
                    err_set[ERR_VERSION] = (sh_ver != VERSION);
                    err_set[ERR_TYPE]    = !type_ok(sh_type, TYPE_MASK);
                    err_set[ERR_RSV]     = sh_rsv;
                    err_set[ERR_LEN]     = (sh_len == '0) ||
                                           (sh_len > MAX_LEN);
                    nxt = (err_set != '0) ? S_ERROR : S_HCKSUM;
                end
            end
            S_HCKSUM: if (rd && ck_last) begin
                if (ck_ok) begin
                    clear = 1'b1;
                    nxt   = S_PAYLOAD;
                end else begin
                    err_set[ERR_HCKSUM] = 1'b1;
                    nxt = S_ERROR;
                end
            end
            S_PAYLOAD: if (rd) begin
`ifdef INPKT_PAYLOAD_CKSUM_EN
                add_en = 1'b1;
                if (rem == 24'd1) nxt = S_PCKSUM;
`else
                if (rem == 24'd1) nxt = S_HDR;
`endif
            end
            S_PCKSUM: begin
`ifdef INPKT_PAYLOAD_CKSUM_EN
                if (rd && ck_last) begin
                    if (ck_ok) begin
                        clear = 1'b1;
                        nxt   = S_HDR;
                    end else begin
                        err_set[ERR_PCKSUM] = 1'b1;
                        nxt = S_ERROR;
                    end
                end
`else
                nxt = S_ERROR;
`endif
            end
            S_ERROR: nxt = S_ERROR;
            default: nxt = S_ERROR;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            cbad    <= 1'b0;
            rem     <= '0;
            sh_ver  <= '0;
            sh_type <= '0;
            sh_len  <= '0;
            sh_id   <= '0;
            sh_rsv  <= 1'b0;
            dout_q  <= '0;
            wr_q    <= 1'b0;
            type_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= '0;
        end else begin
            wr_q    <= 1'b0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            err_q   <= err_q | err_set;
            if (rd) begin
                unique case (state)
                    S_HDR: begin
                        cnt <= hdr_last ? '0 : cnt + 4'd1;
                        unique case (cnt)
                            OFF_VER: begin
                                sh_ver <= bus.din;
                                sh_rsv <= 1'b0;
                            end
                            OFF_TYPE: sh_type <= bus.din;
                            OFF_RSV0, OFF_RSV1, OFF_RSV2:
                                sh_rsv <= sh_rsv | (bus.din != 8'h00);
                            OFF_LEN0: sh_len[7:0]   <= bus.din;
                            OFF_LEN1: sh_len[15:8]  <= bus.din;
                            OFF_LEN2: sh_len[23:16] <= bus.din;
                            OFF_ID0:  sh_id[7:0]    <= bus.din;
                            OFF_ID1:  sh_id[15:8]   <= bus.din;
                            default: ;
                        endcase
                    end
                    S_HCKSUM: begin
                        cnt  <= ck_last ? '0 : cnt + 4'd1;
                        cbad <= ck_last ? 1'b0 : (cbad | !match);
                        if (ck_last && ck_ok) begin
                            type_q  <= sh_type;
                            id_q    <= sh_id;
                            len_q   <= sh_len;
                            rem     <= sh_len;
                            start_q <= 1'b1;
                        end
                    end
                    S_PAYLOAD: begin
                        dout_q <= bus.din;
                        wr_q   <= 1'b1;
                        rem    <= rem - 24'd1;
`ifndef INPKT_PAYLOAD_CKSUM_EN
                        end_q  <= (rem == 24'd1);
`endif
                    end
`ifdef INPKT_PAYLOAD_CKSUM_EN
                    S_PCKSUM: begin
                        cnt   <= ck_last ? '0 : cnt + 4'd1;
                        cbad  <= ck_last ? 1'b0 : (cbad | !match);
                        end_q <= ck_last && ck_ok;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_en     = rd;
    assign bus.dout      = dout_q;
    assign bus.wr_en     = wr_q;
    assign bus.pkt_type  = type_q;
    assign bus.pkt_id    = id_q;
    assign bus.pkt_len   = len_q;
    assign bus.pkt_start = start_q;
    assign bus.pkt_end   = end_q;
    assign bus.err       = err_q;

endmodule
